// File: rtl/grant_tenure_monitor_pkg.sv
// Shared types and constants for the grant tenure monitor.
package grant_tenure_monitor_pkg;

    localparam int unsigned NUM_AGENTS = 4;
    localparam int unsigned AGENT_W    = 2;
    localparam int unsigned TENURE_W   = 8;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_HELD  = 2'd1,
        MON_DRAIN = 2'd2
    } mon_state_e;

    // Index of the lowest set bit; only meaningful for a one-hot vector.
    function automatic logic [AGENT_W-1:0] agent_index(input logic [NUM_AGENTS-1:0] v);
        logic [AGENT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AGENT_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_tenure_monitor_cooldown_ctr.sv
// Per-agent cooldown counter: load arms the mask, which drops as the count hits zero.
module cooldown_ctr #(
    parameter int unsigned COOLDOWN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic blk
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blk_q, blk_d;

    // A reload while already counting restarts the full cooldown.
    always_comb begin
        cnt_d = cnt_q;
        blk_d = blk_q;
        if (load) begin
            cnt_d = CNT_W'(COOLDOWN);
            blk_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                blk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            blk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end

    assign blk = blk_q;

endmodule

// File: rtl/grant_tenure_monitor.sv
// Watches arbiter grants, times out agents holding a grant too long and masks them for a cooldown.
// Optional per-agent grant statistics are built when GNT_STATS_EN is defined.
module grant_tenure_monitor
    import grant_tenure_monitor_pkg::*;
#(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned COOLDOWN   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic              gnt_3,
    input  logic              req_in_0,
    input  logic              req_in_1,
    input  logic              req_in_2,
    input  logic              req_in_3,
    input  logic              clr_err,
    output logic              req_out_0,
    output logic              req_out_1,
    output logic              req_out_2,
    output logic              req_out_3,
    output logic              timeout,
    output logic [AGENT_W-1:0] timeout_id,
    output logic              multi_gnt_err
`ifdef GNT_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt_0,
    output logic [STAT_W-1:0] grant_cnt_1,
    output logic [STAT_W-1:0] grant_cnt_2,
    output logic [STAT_W-1:0] grant_cnt_3
`endif
);

    logic [NUM_AGENTS-1:0] gnt;
    logic [NUM_AGENTS-1:0] blk;
    logic [NUM_AGENTS-1:0] load_c;
    logic                  multi_c;
    logic                  single_c;
    logic [AGENT_W-1:0]    gnt_idx_c;

    mon_state_e            state_q, state_d;
    logic [TENURE_W-1:0]   tenure_q, tenure_d;
    logic [AGENT_W-1:0]    cur_id_q, cur_id_d;
    logic                  timeout_q, timeout_d;
    logic [AGENT_W-1:0]    timeout_id_q, timeout_id_d;
    logic                  err_q, err_d;

    assign gnt       = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign multi_c   = (gnt & (gnt - NUM_AGENTS'(1))) != '0;
    assign single_c  = (gnt != '0) && !multi_c;
    assign gnt_idx_c = agent_index(gnt);

    // Next-state and tenure tracking; an overlap of grants overrides everything else.
    always_comb begin
        state_d      = state_q;
        tenure_d     = tenure_q;
        cur_id_d     = cur_id_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        load_c       = '0;
        err_d        = multi_c | (err_q & ~clr_err);

        if (multi_c) begin
            state_d  = MON_IDLE;
            tenure_d = '0;
        end else begin
            unique case (state_q)
                MON_IDLE: begin
                    if (single_c) begin
                        state_d  = MON_HELD;
                        cur_id_d = gnt_idx_c;
                        tenure_d = TENURE_W'(1);
                    end
                end
                MON_HELD: begin
                    if (!single_c) begin
                        state_d  = MON_IDLE;
                        tenure_d = '0;
                    end else if (gnt_idx_c != cur_id_q) begin
                        cur_id_d = gnt_idx_c;
                        tenure_d = TENURE_W'(1);
                    end else if (tenure_q == TENURE_W'(MAX_TENURE)) begin
                        timeout_d         = 1'b1;
                        timeout_id_d      = cur_id_q;
                        load_c[cur_id_q]  = 1'b1;
                        state_d           = MON_DRAIN;
                    end else begin
                        tenure_d = tenure_q + TENURE_W'(1);
                    end
                end
                MON_DRAIN: begin
                    if (!gnt[cur_id_q]) begin
                        state_d  = MON_IDLE;
                        tenure_d = '0;
                    end
                end
                default: begin
                    state_d  = MON_IDLE;
                    tenure_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= MON_IDLE;
            tenure_q     <= '0;
            cur_id_q     <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tenure_q     <= tenure_d;
            cur_id_q     <= cur_id_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            err_q        <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_cool
        cooldown_ctr #(
            .COOLDOWN (COOLDOWN)
        ) u_cool (
            .clock (clock),
            .reset (reset),
            .load  (load_c[g]),
            .blk   (blk[g])
        );
    end

    assign req_out_0     = req_in_0 & ~blk[0];
    assign req_out_1     = req_in_1 & ~blk[1];
    assign req_out_2     = req_in_2 & ~blk[2];
    assign req_out_3     = req_in_3 & ~blk[3];
    assign timeout       = timeout_q;
    assign timeout_id    = timeout_id_q;
    assign multi_gnt_err = err_q;

`ifdef GNT_STATS_EN
    logic [NUM_AGENTS-1:0] gnt_prev_q, gnt_prev_d;
    logic [STAT_W-1:0]     grant_cnt_q [NUM_AGENTS];
    logic [STAT_W-1:0]     grant_cnt_d [NUM_AGENTS];

    // Count grant rising edges, saturating; clr_err wipes the counts.
    always_comb begin
        gnt_prev_d = gnt;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (clr_err) begin
                grant_cnt_d[i] = '0;
            end else if (gnt[i] && !gnt_prev_q[i] && (grant_cnt_q[i] != {STAT_W{1'b1}})) begin
                grant_cnt_d[i] = grant_cnt_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_prev_q <= '0;
            for (int i = 0; i < NUM_AGENTS; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            gnt_prev_q <= gnt_prev_d;
            for (int i = 0; i < NUM_AGENTS; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    assign grant_cnt_0 = grant_cnt_q[0];
    assign grant_cnt_1 = grant_cnt_q[1];
    assign grant_cnt_2 = grant_cnt_q[2];
    assign grant_cnt_3 = grant_cnt_q[3];
`endif

endmodule
